// File: rtl/nios_data_in.sv
// rtl/nios_data_in.sv - Avalon-MM parallel input port with synchronizer, edge capture and optional irq (NIOS_DATA_IN_IRQ_EN)
module nios_data_in #(
  parameter int WIDTH     = 12,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
`ifdef NIOS_DATA_IN_IRQ_EN
  output logic             irq,
`endif
  output logic [31:0]      readdata
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_d1;
  logic [1:0]       r_prime;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;
`ifdef NIOS_DATA_IN_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;
`endif

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & write_n;

  // Upper writedata bits beyond WIDTH have no destination.
  assign w_unused_wdata = ^writedata;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_d1 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_d1 <= r_s2;
    end
  end

  // Warm-up counter: holds edge detection off until the chain is filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prime <= 2'd0;
    end else if (r_prime != 2'd3) begin
      r_prime <= r_prime + 2'd1;
    end
  end

  // Per-bit edge detection selected by EDGE_TYPE, gated by warm-up.
  always_comb begin
    w_edge_raw = '0;
    if (EDGE_TYPE == 0) begin
      w_edge_raw = r_s2 & ~r_d1;
    end else if (EDGE_TYPE == 1) begin
      w_edge_raw = ~r_s2 & r_d1;
    end else begin
      w_edge_raw = r_s2 ^ r_d1;
    end
    w_edge = (r_prime == 2'd3) ? w_edge_raw : '0;
  end

  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Sticky capture with write-one-to-clear; a new edge beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

`ifdef NIOS_DATA_IN_IRQ_EN
  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask <= '0;
    end else if (w_wr && address == 2'd2) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(r_edgecap & r_irqmask);
`endif

  // Read mux, zero-extended to the 32-bit bus.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0: w_rd_mux[WIDTH-1:0] = r_s2;
`ifdef NIOS_DATA_IN_IRQ_EN
      2'd2: w_rd_mux[WIDTH-1:0] = r_irqmask;
`endif
      2'd3: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default: w_rd_mux = '0;
    endcase
  end

  // Registered read data, loaded only on a read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;

endmodule
